dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder: services the load/store requests the core raises for
//  LW, LBU, SW and SB (load/store/byte qualifiers from the decode stage).
//  Owns a word-organised synchronous-read memory array. Byte stores use
//  read-modify-write. Every request gets exactly one response; the core stalls
//  its memory stage on the response handshake.
// PARAMETERS
//  ADDR_W   10   word-address width; array depth = 2**ADDR_W words of 32 bits
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  req_valid_i   in   1   request present
//  req_ready_o   out  1   responder idle, can accept request this cycle
//  req_store_i   in   1   1 = store (SW/SB), 0 = load (LW/LBU)
//  req_byte_i    in   1   1 = byte op (LBU/SB), 0 = word op (LW/SW)
//  req_addr_i    in   32  byte address
//  req_wdata_i   in   32  store data; SB uses [7:0]
//  resp_valid_o  out  1   response present
//  resp_yumi_i   in   1   core consumes response (only legal when resp_valid_o)
//  resp_rdata_o  out  32  load data; 0 for stores
//  resp_err_o    out  1   misaligned word access (only with DMEM_ALIGN_CHECK_EN)
// BEHAVIOUR
//  - Reset (async): state=IDLE, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
//    req_ready_o = (state==IDLE) & ~reset. Memory contents NOT cleared.
//  - Accept: req_valid_i & req_ready_o at edge; request fields latched.
//  - Word index = addr[ADDR_W+1:2]; lane = addr[1:0], little-endian. Bits above
//    ADDR_W+1 ignored (aliasing). Word ops ignore addr[1:0] unless macro on.
//  - FSM: IDLE, RD, WR, RESP. Accept cycle = T.
//    LW : IDLE -(accept, array read issued)-> RD -(latch word)-> RESP; valid T+2.
//    LBU: as LW; rdata = {24'b0, lane byte}; valid T+2.
//    SW : IDLE -> WR (full word written at end of WR) -> RESP; valid T+2.
//    SB : IDLE -> RD (old word) -> WR (write old word with lane replaced by
//         wdata[7:0]) -> RESP; valid T+3.
//    RESP: resp_valid_o=1, rdata/err held stable until resp_yumi_i; on yumi
//         -> IDLE; req_ready_o=1 next cycle (no same-cycle re-accept).
//  - Only one request in flight; req_ready_o=0 in RD/WR/RESP.
//  - Array written only in WR; exactly one write per store, none per load.
//  - Reset mid-op: abort to IDLE; a store whose WR edge has not occurred is not
//    committed; pending response dropped.
//  - resp_yumi_i outside RESP is ignored.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined: word op with addr[1:0]!=0 skips array access,
//    IDLE -> RESP directly (valid T+1), resp_err_o=1, resp_rdata_o=0, no write.
//    resp_err_o=0 on every other response. Byte ops never flag.
//  Undefined: resp_err_o tied 0; addr[1:0] ignored for word ops.
// TESTING
//  1 reset held 3 cycles, released -> req_ready_o=1, resp_valid_o=0, rdata=0.
//  2 SW 0x10 data 0xDEADBEEF, then LW 0x10 -> resp at T+2, rdata=0xDEADBEEF.
//  3 after (2): SB 0x11 data 0x55 (valid T+3); LW 0x10 -> 0xDEAD55EF;
//    LBU 0x13 -> 0x000000DE.
//  4 LW with resp_yumi_i low 5 cycles, req_valid_i high -> rdata stable,
//    req_ready_o=0, 2nd request accepted only cycle after yumi.
//  5 reset asserted in RD of SB 0x10 data 0xAA -> IDLE, LW 0x10 returns prior word.
//  6 LW 0x12 after (2): macro on -> err=1, rdata=0, valid T+1; off -> 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder for LW/LBU/SW/SB with one request in flight.
// Optional macro DMEM_ALIGN_CHECK_EN: flag misaligned word accesses instead of ignoring addr[1:0].
module dmem_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_yumi_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | array read word available (load result or old word for SB)
  // WR    | array written at the end of this cycle
  // RESP  | response presented until resp_yumi_i
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]       r_mem_rdata;
  logic              r_store;
  logic              r_byte;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_req_idx;
  logic [7:0]        w_lane_byte;
  logic [31:0]       w_merged;
  logic [31:0]       w_wr_word;
  logic              w_unused_addr;

  assign req_ready_o   = (r_state == IDLE) & ~reset;
  assign w_accept      = req_valid_i & req_ready_o;
  assign w_req_idx     = req_addr_i[ADDR_W+1:2];
  assign w_unused_addr = ^req_addr_i[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = ~req_byte_i & (req_addr_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_lane_byte = r_mem_rdata[7:0];
    w_merged    = r_mem_rdata;
    case (r_lane)
      2'd0: begin w_lane_byte = r_mem_rdata[7:0];   w_merged[7:0]   = r_wdata[7:0]; end
      2'd1: begin w_lane_byte = r_mem_rdata[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
      2'd2: begin w_lane_byte = r_mem_rdata[23:16]; w_merged[23:16] = r_wdata[7:0]; end
      default: begin w_lane_byte = r_mem_rdata[31:24]; w_merged[31:24] = r_wdata[7:0]; end
    endcase
    w_wr_word = r_byte ? w_merged : r_wdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_misalign)                     w_next = RESP;
          else if (req_store_i & ~req_byte_i) w_next = WR;
          else                                w_next = RD;
        end
      end
      RD:      w_next = r_store ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (resp_yumi_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_store <= 1'b0;
      r_byte  <= 1'b0;
      r_lane  <= 2'b00;
      r_idx   <= '0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_store <= req_store_i;
        r_byte  <= req_byte_i;
        r_lane  <= req_addr_i[1:0];
        r_idx   <= w_req_idx;
        r_wdata <= req_wdata_i;
        if (w_misalign) begin
          r_rdata <= 32'h0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == RD && !r_store) begin
        r_rdata <= r_byte ? {24'h0, w_lane_byte} : r_mem_rdata;
        r_err   <= 1'b0;
      end
      if (r_state == WR) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array has no reset: contents survive reset, and the read port is issued on accept.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_mem_rdata <= r_mem[w_req_idx];
    if (r_state == WR)
      r_mem[r_idx] <= w_wr_word;
  end

  assign resp_valid_o = (r_state == RESP);
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-level memory model, random and directed traffic.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_store_i;
  logic        req_byte_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_yumi_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  dmem_responder #(.ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_store_i(req_store_i), .req_byte_i(req_byte_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_yumi_i(resp_yumi_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
    int          ydly;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  mb [0:63];   // 16 words modelled as bytes; addr[11:6] kept 0, upper bits alias
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          holding = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] w, input logic [1:0] ln, input logic [19:0] up);
    return {up, 6'b0, w, ln};
  endfunction

  task automatic issue(input bit st, input bit bt, input logic [31:0] a,
                       input logic [31:0] wd, input int ydly, input bit track);
    int n;
    int off;
    int ln;
    exp_t e;
    logic [3:0] w;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_store_i = st;
    req_byte_i  = bt;
    req_addr_i  = a;
    req_wdata_i = wd;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 100 cycles");
      req_valid_i = 1'b0;
      return;
    end
    if (track) begin
      w   = a[5:2];
      off = int'(w) * 4;
      ln  = int'(a[1:0]);
      e.ydly = ydly; e.acc_cyc = cyc; e.err = 1'b0; e.rdata = 32'h0;
      if (ALIGN && !bt && a[1:0] != 2'b00) begin
        e.err = 1'b1; e.lat = 1;
      end else if (st) begin
        if (bt) mb[off+ln] = wd[7:0];
        else for (int i = 0; i < 4; i++) mb[off+i] = wd[8*i +: 8];
        e.lat = bt ? 3 : 2;
      end else begin
        if (bt) e.rdata = {24'h0, mb[off+ln]};
        else    e.rdata = {mb[off+3], mb[off+2], mb[off+1], mb[off]};
        e.lat = 2;
      end
      sb_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    req_valid_i = 1'b0;
    while ((sb_q.size() != 0 || holding) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (sb_q.size() != 0 || holding) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  // Monitor: pops one expectation per response, checks hold stability, then consumes.
  initial begin : monitor
    exp_t        e;
    logic [31:0] h_rdata;
    logic        h_err;
    int          wait_left;
    bit          yumi_sent;
    resp_yumi_i = 1'b0;
    yumi_sent = 0;
    wait_left = 0;
    h_rdata = 32'h0;
    h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holding = 0;
        yumi_sent = 0;
        resp_yumi_i = 1'b0;
      end else if (yumi_sent) begin
        resp_yumi_i = 1'b0;
        yumi_sent = 0;
        holding = 0;
        chk("valid_after_yumi", {31'h0, resp_valid_o}, 32'h0);
        chk("ready_after_yumi", {31'h0, req_ready_o}, 32'h1);
      end else if (resp_valid_o) begin
        if (!holding) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_resp: got rdata 0x%08h expected no response", resp_rdata_o);
            wait_left = 0;
          end else begin
            e = sb_q.pop_front();
            chk("rdata", resp_rdata_o, e.rdata);
            chk("err", {31'h0, resp_err_o}, {31'h0, e.err});
            chk("latency", cyc - e.acc_cyc, e.lat);
            wait_left = e.ydly;
          end
          holding = 1;
          h_rdata = resp_rdata_o;
          h_err   = resp_err_o;
        end else begin
          chk("rdata_hold", resp_rdata_o, h_rdata);
          chk("err_hold", {31'h0, resp_err_o}, {31'h0, h_err});
          chk("ready_in_resp", {31'h0, req_ready_o}, 32'h0);
        end
        if (wait_left == 0) begin
          resp_yumi_i = 1'b1;
          yumi_sent = 1;
        end else begin
          wait_left--;
        end
      end
    end
  end

  initial begin : stim
    logic [3:0]  rw;
    logic [1:0]  rl;
    logic [19:0] ru;
    bit          rs, rb;
    reset = 1'b1;
    req_valid_i = 1'b0; req_store_i = 1'b0; req_byte_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0;

    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", {31'h0, req_ready_o}, 32'h0);
    end
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_valid", {31'h0, resp_valid_o}, 32'h0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_err", {31'h0, resp_err_o}, 32'h0);

    for (int w = 0; w < 16; w++)
      issue(1'b1, 1'b0, mk(4'(w), 2'b00, 20'($urandom)), $urandom, 0, 1'b1);

    issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b1);
    issue(1'b1, 1'b1, 32'h11, 32'h00000055, 0, 1'b1);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b1);
    issue(1'b0, 1'b1, 32'h13, 32'h0, 0, 1'b1);

    // Long hold with a second request queued behind it
    issue(1'b0, 1'b0, 32'h10, 32'h0, 5, 1'b1);
    issue(1'b0, 1'b0, 32'h14, 32'h0, 0, 1'b1);
    drain();

    // Reset while SB sits in RD: nothing committed, no response
    issue(1'b1, 1'b1, 32'h10, 32'h000000AA, 0, 1'b0);
    @(negedge clk);
    req_valid_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_ready", {31'h0, req_ready_o}, 32'h0);
    chk("midrst_valid", {31'h0, resp_valid_o}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("postrst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("postrst_rdata", resp_rdata_o, 32'h0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b1);

    issue(1'b0, 1'b0, 32'h12, 32'h0, 0, 1'b1);
    issue(1'b1, 1'b0, 32'h16, 32'h12345678, 1, 1'b1);
    issue(1'b0, 1'b0, 32'h14, 32'h0, 0, 1'b1);

    for (int k = 0; k < 200; k++) begin
      rw = 4'($urandom);
      rl = 2'($urandom);
      ru = 20'($urandom);
      rs = 1'($urandom);
      rb = 1'($urandom);
      issue(rs, rb, mk(rw, rl, ru), $urandom, int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        req_valid_i = 1'b0;
      end
    end
    drain();
    chk("queue_empty", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
